// File: rtl/pb_intc.sv
`default_nettype none
// ============================================================================
//  Module      : pb_intc
//  Description : N-source interrupt controller for the PicoBlaze peripheral
//                bus with edge/level sources, masking, fixed priority and an
//                ack/EOI service handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module pb_intc #(
    parameter int N_SRC       = 8,
    parameter int ID_W        = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_SRC-1:0]  int_src,
    input  logic [N_SRC-1:0]  int_mask,
    input  logic [N_SRC-1:0]  int_edge,
    input  logic [N_SRC-1:0]  int_pol,
    input  logic [N_SRC-1:0]  int_clear,
    input  logic              int_ack,
    input  logic              int_eoi,
    output logic [N_SRC-1:0]  pending,
    output logic              int_o,
    output logic [ID_W-1:0]   int_id,
    output logic              int_busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             r_state;
    logic [N_SRC-1:0]   r_sync [SYNC_STAGES];
    logic [N_SRC-1:0]   r_hist;
    logic [N_SRC-1:0]   r_edge_pend;
    logic [N_SRC-1:0]   r_lvl_pend;
    logic               r_int;
    logic [ID_W-1:0]    r_id;
    logic               r_busy;

    logic [N_SRC-1:0]   w_act;
    logic [N_SRC-1:0]   w_rise;
    logic [N_SRC-1:0]   w_en;
    logic [N_SRC-1:0]   w_ack_clr;
    logic [N_SRC-1:0]   w_edge_nxt;
    logic [N_SRC-1:0]   w_lvl_nxt;
    logic [ID_W-1:0]    w_win;
    logic               w_cur_en;

    // Metastability chain for the asynchronous source lines.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= int_src;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_act  = r_sync[SYNC_STAGES-1] ^ ~int_pol;
    assign w_rise = w_act & ~r_hist;

    generate
        for (genvar i = 0; i < N_SRC; i++) begin : g_src
            assign w_ack_clr[i] = (r_state == ST_REQ) && int_ack &&
                                  (r_id == ID_W'(i));

            // A new edge beats any clear arriving in the same cycle.
            assign w_edge_nxt[i] = int_edge[i] &
                                   (w_rise[i] |
                                    (r_edge_pend[i] & ~int_clear[i] & ~w_ack_clr[i]));

            assign w_lvl_nxt[i]  = ~int_edge[i] & w_act[i];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hist      <= '0;
            r_edge_pend <= '0;
            r_lvl_pend  <= '0;
        end else begin
            r_hist      <= w_act;
            r_edge_pend <= w_edge_nxt;
            r_lvl_pend  <= w_lvl_nxt;
        end
    end

    assign pending = r_edge_pend | r_lvl_pend;
    assign w_en    = pending & ~int_mask;

    // Scan from the top so the lowest enabled index is the last assignment.
    always_comb begin
        w_win = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_en[i]) begin
                w_win = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_cur_en = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_id == ID_W'(i)) begin
                w_cur_en = w_en[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_int   <= 1'b0;
            r_id    <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_en != '0) begin
                        r_state <= ST_REQ;
                        r_id    <= w_win;
                        r_int   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // The vector is frozen while requested; ack takes
                    // precedence over the request disappearing.
                    if (int_ack) begin
                        r_state <= ST_SERVICE;
                        r_int   <= 1'b0;
                        r_busy  <= 1'b1;
                    end else if (!w_cur_en) begin
                        r_state <= ST_IDLE;
                        r_int   <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (int_eoi) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_int   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign int_o    = r_int;
    assign int_id   = r_id;
    assign int_busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_pb_intc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pb_intc
//  Description : Self-checking bench for pb_intc (directed scenarios plus
//                randomized multi-source service order).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pb_intc;

    localparam int c_n  = 8;
    localparam int c_id = 3;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [c_n-1:0]    int_src, int_mask, int_edge, int_pol, int_clear;
    logic              int_ack, int_eoi;
    logic [c_n-1:0]    pending;
    logic              int_o;
    logic [c_id-1:0]   int_id;
    logic              int_busy;

    int checks   = 0;
    int failures = 0;

    pb_intc #(.N_SRC(c_n), .ID_W(c_id), .SYNC_STAGES(2)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .int_src   (int_src),
        .int_mask  (int_mask),
        .int_edge  (int_edge),
        .int_pol   (int_pol),
        .int_clear (int_clear),
        .int_ack   (int_ack),
        .int_eoi   (int_eoi),
        .pending   (pending),
        .int_o     (int_o),
        .int_id    (int_id),
        .int_busy  (int_busy)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        int_src   = '0;
        int_mask  = '0;
        int_edge  = '1;
        int_pol   = '1;
        int_clear = '0;
        int_ack   = 1'b0;
        int_eoi   = 1'b0;
        rst_i     = 1'b1;
        tick();
        tick();
        rst_i     = 1'b0;
    endtask

    task automatic wait_int(input string tag, input int max_cyc);
        int n = 0;
        while (!int_o && n < max_cyc) begin
            tick();
            n++;
        end
        checks++;
        if (int_o !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout: int_o=%b after %0d cycles, required 1", tag, int_o, n);
        end
    endtask

    task automatic ack_pulse();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic eoi_pulse();
        int_eoi = 1'b1;
        tick();
        int_eoi = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({pending, int_o, int_id, int_busy} !== '0) begin
            failures++;
            $display("FAIL reset_state: pend=%h int_o=%b id=%0d busy=%b, required all 0",
                     pending, int_o, int_id, int_busy);
        end
    endtask

    task automatic test_edge_latency();
        do_reset();
        int_src[3] = 1'b1;
        tick();                     // edge T
        tick();                     // T+1
        checks++;
        if (pending[3] !== 1'b0) begin
            failures++;
            $display("FAIL lat_early: pending[3]=%b at T+1, required 0", pending[3]);
        end
        tick();                     // T+2
        checks++;
        if (pending[3] !== 1'b1 || int_o !== 1'b0) begin
            failures++;
            $display("FAIL lat_pend: pending[3]=%b int_o=%b at T+2, required 1/0", pending[3], int_o);
        end
        tick();                     // T+3
        checks++;
        if (int_o !== 1'b1 || int_id !== 3'd3) begin
            failures++;
            $display("FAIL lat_req: int_o=%b id=%0d at T+3, required 1/3", int_o, int_id);
        end
        ack_pulse();
        checks++;
        if (int_o !== 1'b0 || int_busy !== 1'b1 || pending[3] !== 1'b0) begin
            failures++;
            $display("FAIL edge_ack: int_o=%b busy=%b pending[3]=%b, required 0/1/0",
                     int_o, int_busy, pending[3]);
        end
        eoi_pulse();
        checks++;
        if (int_busy !== 1'b0) begin
            failures++;
            $display("FAIL edge_eoi: busy=%b, required 0", int_busy);
        end
    endtask

    task automatic test_priority();
        do_reset();
        int_src[5] = 1'b1;
        int_src[1] = 1'b1;
        wait_int("prio_first", 10);
        checks++;
        if (int_id !== 3'd1) begin
            failures++;
            $display("FAIL prio_first_id: id=%0d, required 1", int_id);
        end
        ack_pulse();
        eoi_pulse();
        checks++;
        if (int_o !== 1'b0) begin
            failures++;
            $display("FAIL prio_gap: int_o=%b on EOI cycle, required 0", int_o);
        end
        tick();
        checks++;
        if (int_o !== 1'b1 || int_id !== 3'd5) begin
            failures++;
            $display("FAIL prio_second: int_o=%b id=%0d, required 1/5", int_o, int_id);
        end
    endtask

    task automatic test_level();
        bit saw = 1'b0;
        do_reset();
        int_edge[0] = 1'b0;
        int_pol[0]  = 1'b0;         // src0 held low = active
        wait_int("lvl_first", 10);
        checks++;
        if (int_id !== 3'd0) begin
            failures++;
            $display("FAIL lvl_id: id=%0d, required 0", int_id);
        end
        ack_pulse();
        checks++;
        if (int_busy !== 1'b1 || pending[0] !== 1'b1) begin
            failures++;
            $display("FAIL lvl_ack: busy=%b pending[0]=%b, required 1/1", int_busy, pending[0]);
        end
        eoi_pulse();
        wait_int("lvl_rereq", 5);
        checks++;
        if (int_id !== 3'd0) begin
            failures++;
            $display("FAIL lvl_rereq_id: id=%0d, required 0", int_id);
        end
        ack_pulse();
        int_src[0] = 1'b1;
        repeat (4) tick();
        eoi_pulse();
        for (int i = 0; i < 6; i++) begin
            tick();
            if (int_o) saw = 1'b1;
        end
        checks++;
        if (pending[0] !== 1'b0 || saw) begin
            failures++;
            $display("FAIL lvl_release: pending[0]=%b int_seen=%b, required 0/0", pending[0], saw);
        end
    endtask

    task automatic test_mask();
        do_reset();
        int_src[2] = 1'b1;
        wait_int("mask_req", 10);
        int_mask[2] = 1'b1;
        tick();
        checks++;
        if (int_o !== 1'b0 || pending[2] !== 1'b1) begin
            failures++;
            $display("FAIL mask_drop: int_o=%b pending[2]=%b, required 0/1", int_o, pending[2]);
        end
        tick();
        tick();
        checks++;
        if (int_o !== 1'b0) begin
            failures++;
            $display("FAIL mask_hold: int_o=%b, required 0", int_o);
        end
        int_mask[2] = 1'b0;
        wait_int("mask_rereq", 5);
        checks++;
        if (int_id !== 3'd2) begin
            failures++;
            $display("FAIL mask_rereq_id: id=%0d, required 2", int_id);
        end
    endtask

    task automatic test_set_wins();
        do_reset();
        int_mask[4] = 1'b1;
        int_src[4]  = 1'b1;
        tick();
        tick();
        int_clear[4] = 1'b1;        // coincides with the edge being latched
        tick();
        int_clear[4] = 1'b0;
        checks++;
        if (pending[4] !== 1'b1) begin
            failures++;
            $display("FAIL set_wins: pending[4]=%b, required 1", pending[4]);
        end
        int_clear[4] = 1'b1;
        tick();
        int_clear[4] = 1'b0;
        checks++;
        if (pending[4] !== 1'b0) begin
            failures++;
            $display("FAIL clear: pending[4]=%b, required 0", pending[4]);
        end
    endtask

    task automatic test_reset_service();
        do_reset();
        int_src[3] = 1'b1;
        wait_int("rs_req", 10);
        ack_pulse();
        int_src[3] = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checks++;
        if (int_busy !== 1'b0 || int_o !== 1'b0 || pending !== '0) begin
            failures++;
            $display("FAIL rst_service: busy=%b int_o=%b pend=%h, required 0/0/0",
                     int_busy, int_o, pending);
        end
        ack_pulse();
        eoi_pulse();
        tick();
        checks++;
        if (int_busy !== 1'b0 || int_o !== 1'b0) begin
            failures++;
            $display("FAIL stray_idle: busy=%b int_o=%b, required 0/0", int_busy, int_o);
        end
        int_src[6] = 1'b1;
        wait_int("rs_new", 10);
        eoi_pulse();
        checks++;
        if (int_o !== 1'b1 || int_busy !== 1'b0 || int_id !== 3'd6) begin
            failures++;
            $display("FAIL stray_eoi_req: int_o=%b busy=%b id=%0d, required 1/0/6",
                     int_o, int_busy, int_id);
        end
    endtask

    // Every unmasked source that fired is served exactly once, lowest index first.
    task automatic test_random_order();
        for (int it = 0; it < 10; it++) begin
            logic [c_n-1:0] set, msk;
            int exp_q[$];
            set = c_n'($urandom_range(1, 255));
            msk = c_n'($urandom);
            for (int i = 0; i < c_n; i++) begin
                if (set[i] && !msk[i]) exp_q.push_back(i);
            end
            do_reset();
            int_mask = msk;
            int_src  = set;
            while (exp_q.size() > 0) begin
                int e = exp_q.pop_front();
                wait_int("rnd_req", 20);
                checks++;
                if (int_id !== c_id'(e)) begin
                    failures++;
                    $display("FAIL rnd_order: iter %0d id=%0d, required %0d", it, int_id, e);
                end
                ack_pulse();
                repeat ($urandom_range(0, 3)) tick();
                eoi_pulse();
            end
            repeat (5) tick();
            checks++;
            if (int_o !== 1'b0 || pending !== (set & msk)) begin
                failures++;
                $display("FAIL rnd_final: iter %0d int_o=%b pend=%h, required 0/%h",
                         it, int_o, pending, set & msk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_edge_latency();
        test_priority();
        test_level();
        test_mask();
        test_set_wins();
        test_reset_service();
        test_random_order();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
